cfg_strobe_tx: RTL
==================

// Module: cfg_strobe_tx
// PURPOSE
// - Transmitter side of the synth's byte-wide config port; drives ui_in/uio_in of a synth instance in test
//   harnesses and on companion controller designs.
// - Accepts 16-bit config-word writes (addr 0-7, byte enables) on a valid/ready interface and buffers them
//   in a small FIFO.
// - Serializes each word into strobed byte transfers: data, word address, byte select, then a strobe pulse.
// - Strobe timing tolerates the receiver's 2-flop strobe synchronizer and its one-cycle-per-retry write deferral.
// PARAMETERS
// - FIFO_LOG2    default 2  FIFO depth = 2**FIFO_LOG2 words.
// - SETUP_CYCLES default 2  cycles data/addr are stable before strobe rises (>=1).
// - HIGH_CYCLES  default 8  cycles strobe held high (>=4; covers sync latency plus deferral retries).
// - LOW_CYCLES   default 4  cycles strobe held low after fall, data/addr still held (>=3).
// PORTS
// - clk        in   1   clock.
// - rst_n      in   1   asynchronous active-low reset.
// - s_valid    in   1   write request valid.
// - s_ready    out  1   FIFO not full; transfer occurs when s_valid & s_ready.
// - s_addr     in   3   config word address.
// - s_data     in   16  config word; [7:0] low byte, [15:8] high byte.
// - s_be       in   2   byte enables; [0] low byte, [1] high byte.
// - cfg_data   out  8   byte to the receiver's ui_in.
// - cfg_addr   out  3   word address, to uio_in[3:1].
// - cfg_addr0  out  1   byte select (0 = low byte, 1 = high byte), to uio_in[0].
// - cfg_strobe out  1   write strobe, to uio_in[7].
// - busy       out  1   high when FIFO is non-empty or FSM is not IDLE.
// BEHAVIOUR
// - Async reset clears:
//   - cfg_data, cfg_addr, cfg_addr0, cfg_strobe = 0; busy = 0.
//   - FIFO pointers; FSM = IDLE.
// - s_ready is 1 from the first clock after reset release.
// - All cfg_* outputs are registered; no combinational path from s_* to cfg_*.
// - FIFO:
//   - Stores {addr, data, be}; push when s_valid & s_ready.
//   - Pop only in IDLE.
//   - Push into a full FIFO is impossible (s_ready = 0). Simultaneous push and pop is allowed.
//   - s_ready = !full, combinational from pointers.
// - FSM states: IDLE, SETUP, HIGH, LOW. A down-counter sized for max(SETUP, HIGH, LOW) is loaded on
//   every state entry.
//   - IDLE, FIFO non-empty: pop into the working register.
//     - be == 2'b00: word is dropped, stays in IDLE, no bus activity.
//     - Otherwise the first enabled byte (low first) is selected. Next cycle: cfg_data/addr/addr0 are
//       updated, FSM enters SETUP.
//   - SETUP: cfg_strobe = 0 for SETUP_CYCLES cycles, then HIGH.
//   - HIGH: cfg_strobe = 1 for HIGH_CYCLES cycles, then LOW.
//   - LOW: cfg_strobe = 0 for LOW_CYCLES cycles.
//     - If be == 2'b11 and the low byte was just sent: load the high byte (cfg_addr0 = 1), go to SETUP.
//     - Otherwise go to IDLE.
//   - cfg_data/addr/addr0 change only on entry to SETUP and stay constant through SETUP, HIGH and LOW.
//   - After LOW, cfg_* keep their last values in IDLE.
// - Per byte: exactly one 0->1 strobe edge. Byte period = SETUP+HIGH+LOW cycles.
// - Word with both bytes: 2 byte periods. Back-to-back words add 1 IDLE pop cycle each.
// - Reset mid-transfer: strobe drops immediately; FIFO contents are lost; the partial byte is not re-sent.
// - be == 2'b10: only the high byte is sent, with cfg_addr0 = 1.
// - FIFO pointers are FIFO_LOG2+1 bits and wrap naturally; full and empty are distinguished by the MSB.
// TESTING
// - Reset release, then push addr=3 data=16'hA55A be=11:
//   - Bytes 5A (addr0=0) then A5 (addr0=1), cfg_addr=3.
//   - Each byte: strobe high 8 cycles, preceded by >=2 stable cycles.
//   - busy falls 28 cycles after first cfg change.
// - Push addr=5 data=16'h1234 be=10 -> single transfer, cfg_data=12, cfg_addr0=1. be=00 -> no strobe edge,
//   busy pulses <=1 cycle.
// - Hold s_valid for 6 words with FIFO_LOG2=2 -> s_ready low after 4 accepted.
//   - All 6 words are delivered in order with no loss.
// - Drive into the real synth RX model, with a sweep forcing cfg_override_we during the strobe edge ->
//   receiver cfg[addr] still ends equal to the sent word.
// - Assert rst_n low during HIGH of the first byte -> cfg_strobe=0 asynchronously.
//   - After release: s_ready=1, busy=0, no further strobes.
// - Checker: cfg_data/cfg_addr/cfg_addr0 never change while cfg_strobe=1 or within SETUP_CYCLES before
//   its rise.

Source files
------------

// File: rtl/cfg_strobe_tx_if.sv
// Write-request channel into cfg_strobe_tx.
// One 16-bit config word moves on each cycle where s_valid and s_ready are both high.
//
// Signals:
//   s_valid  master -> slave   write request valid
//   s_ready  slave  -> master  request accepted this cycle when s_valid is high
//   s_addr   master -> slave   config word address (0-7)
//   s_data   master -> slave   config word; [7:0] low byte, [15:8] high byte
//   s_be     master -> slave   byte enables; [0] low byte, [1] high byte
interface cfg_strobe_tx_if;
  logic        s_valid;
  logic        s_ready;
  logic [2:0]  s_addr;
  logic [15:0] s_data;
  logic [1:0]  s_be;

  modport master (
    output s_valid,
    output s_addr,
    output s_data,
    output s_be,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_addr,
    input  s_data,
    input  s_be,
    output s_ready
  );
endinterface

// File: rtl/cfg_strobe_tx.sv
// Transmitter for the synth's byte-wide config port.
// Buffers 16-bit config-word writes in a small FIFO and sends each enabled byte as a strobed
// transfer. For every byte, data, address and byte select are set up first, then a strobe pulse
// follows, and then a low tail during which they are still held. The strobe is long enough to cover
// the receiver's 2-flop synchronizer plus its write-deferral retries.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   req         write-request channel (slave side): s_valid/s_ready/s_addr/s_data/s_be
//   cfg_data    byte to the receiver's ui_in
//   cfg_addr    word address, to uio_in[3:1]
//   cfg_addr0   byte select (0 low, 1 high), to uio_in[0]
//   cfg_strobe  write strobe, to uio_in[7]
//   busy        FIFO non-empty or a transfer in progress
module cfg_strobe_tx #(
  parameter int unsigned FIFO_LOG2    = 2,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned HIGH_CYCLES  = 8,
  parameter int unsigned LOW_CYCLES   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  cfg_strobe_tx_if.slave      req,
  output logic [7:0]          cfg_data,
  output logic [2:0]          cfg_addr,
  output logic                cfg_addr0,
  output logic                cfg_strobe,
  output logic                busy
);

  // ---------------------------------------------------------------------------------------------
  // Phase counter sizing
  // ---------------------------------------------------------------------------------------------
  localparam int unsigned Depth  = 1 << FIFO_LOG2;
  localparam int unsigned CntMax = (SETUP_CYCLES > HIGH_CYCLES) ?
                                   ((SETUP_CYCLES > LOW_CYCLES) ? SETUP_CYCLES : LOW_CYCLES) :
                                   ((HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES);
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  // The counter holds "cycles remaining minus one", so a phase of N cycles loads N-1.
  localparam logic [CntW-1:0] SetupLoad = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] HighLoad  = CntW'(HIGH_CYCLES - 1);
  localparam logic [CntW-1:0] LowLoad   = CntW'(LOW_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow
  } state_e;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
    logic [1:0]  be;
  } entry_t;

  // ---------------------------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------------------------
  // Pointers carry one extra bit so that full and empty differ only in the MSB.
  entry_t             mem_q [Depth];
  logic [FIFO_LOG2:0] wptr_q, wptr_d;
  logic [FIFO_LOG2:0] rptr_q, rptr_d;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  entry_t             head;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[FIFO_LOG2] != rptr_q[FIFO_LOG2]) &&
                      (wptr_q[FIFO_LOG2-1:0] == rptr_q[FIFO_LOG2-1:0]);
  assign req.s_ready = !fifo_full;
  assign push        = req.s_valid && !fifo_full;
  assign head        = mem_q[rptr_q[FIFO_LOG2-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: a word is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[FIFO_LOG2-1:0]] <= '{addr: req.s_addr, data: req.s_data, be: req.s_be};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      hi_byte_q, hi_byte_d;   // high byte kept for the second half of a 2-byte word
  logic            pend_hi_q, pend_hi_d;   // high byte still to send after the current one
  logic [7:0]      cfg_data_q, cfg_data_d;
  logic [2:0]      cfg_addr_q, cfg_addr_d;
  logic            cfg_addr0_q, cfg_addr0_d;
  logic            cfg_strobe_q, cfg_strobe_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_byte_d    = hi_byte_q;
    pend_hi_d    = pend_hi_q;
    cfg_data_d   = cfg_data_q;
    cfg_addr_d   = cfg_addr_q;
    cfg_addr0_d  = cfg_addr0_q;
    cfg_strobe_d = cfg_strobe_q;
    pop          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          // A word with no enabled bytes is consumed without touching the bus.
          if (head.be != 2'b00) begin
            state_d    = StSetup;
            cnt_d      = SetupLoad;
            cfg_addr_d = head.addr;
            hi_byte_d  = head.data[15:8];
            pend_hi_d  = (head.be == 2'b11);
            if (head.be[0]) begin
              cfg_data_d  = head.data[7:0];
              cfg_addr0_d = 1'b0;
            end else begin
              cfg_data_d  = head.data[15:8];
              cfg_addr0_d = 1'b1;
            end
          end
        end
      end

      StSetup: begin
        if (cnt_q == '0) begin
          state_d      = StHigh;
          cnt_d        = HighLoad;
          cfg_strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StHigh: begin
        if (cnt_q == '0) begin
          state_d      = StLow;
          cnt_d        = LowLoad;
          cfg_strobe_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StLow: begin
        if (cnt_q == '0) begin
          if (pend_hi_q) begin
            // Second byte of the same word: address is unchanged, only data and select move.
            state_d     = StSetup;
            cnt_d       = SetupLoad;
            cfg_data_d  = hi_byte_q;
            cfg_addr0_d = 1'b1;
            pend_hi_d   = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d      = StIdle;
        cfg_strobe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hi_byte_q    <= '0;
      pend_hi_q    <= 1'b0;
      cfg_data_q   <= '0;
      cfg_addr_q   <= '0;
      cfg_addr0_q  <= 1'b0;
      cfg_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_byte_q    <= hi_byte_d;
      pend_hi_q    <= pend_hi_d;
      cfg_data_q   <= cfg_data_d;
      cfg_addr_q   <= cfg_addr_d;
      cfg_addr0_q  <= cfg_addr0_d;
      cfg_strobe_q <= cfg_strobe_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign cfg_data   = cfg_data_q;
  assign cfg_addr   = cfg_addr_q;
  assign cfg_addr0  = cfg_addr0_q;
  assign cfg_strobe = cfg_strobe_q;
  assign busy       = !fifo_empty || (state_q != StIdle);

endmodule
